// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretch event strobes into HOLD/GAP level windows with a pending queue
//
// Purpose: every accepted strobe on pulse_in produces HOLD_CYCLES of level_out
// high followed by GAP_CYCLES of forced low. Strobes arriving during a window or
// gap are counted (saturating at QUEUE_DEPTH) and replayed back to back.
//
// Ports:
//   clk_in       system clock, posedge
//   rst_n_in     asynchronous active-low reset
//   pulse_in     event strobe, one event per cycle sampled high
//   level_out    stretched level (registered)
//   busy_out     high whenever not idle (registered)
//   pending_out  queued events not yet started (registered)
//   overflow_out one-cycle pulse after an event is dropped on a full queue
//
// Build option: define PULSE_STRETCHER_RETRIGGER_EN to make a strobe during the
// high window restart it instead of queueing.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 15_000_000,
  parameter int GAP_CYCLES  = 15_000_000,
  parameter int QUEUE_DEPTH = 7,
  parameter int CNT_W       = 32,
  localparam int PEND_W     = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy_out,
  output logic [PEND_W-1:0] pending_out,
  output logic              overflow_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [PEND_W-1:0]  pend_d;
  logic               ovf_d;
  logic               queue_evt;
  logic [PEND_W:0]    eff;
  logic               hold_last;
  logic               gap_last;

  assign hold_last = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  assign gap_last  = (cnt_q == CNT_W'(GAP_CYCLES - 1));

  // Events available to start on the last gap cycle: queued ones plus a strobe
  // arriving right now, so that strobe is consumed rather than queued.
  assign eff = {1'b0, pending_out} + {{PEND_W{1'b0}}, pulse_in};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pending_out;
    ovf_d     = 1'b0;
    queue_evt = 1'b0;

    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end

      HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (pulse_in) begin
          cnt_d = '0;
        end else if (hold_last) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        queue_evt = pulse_in;
        if (hold_last) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      GAP: begin
        if (gap_last) begin
          cnt_d = '0;
          if (eff != '0) begin
            state_d = HOLD;
            pend_d  = PEND_W'(eff - (PEND_W + 1)'(1));
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          queue_evt = pulse_in;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Saturating enqueue; a full queue drops the event and flags it.
    if (queue_evt) begin
      if (pending_out == PEND_W'(QUEUE_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pending_out + PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pending_out  <= '0;
      level_out    <= 1'b0;
      busy_out     <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_out  <= pend_d;
      level_out    <= (state_d == HOLD);
      busy_out     <= (state_d != IDLE);
      overflow_out <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - self-checking bench for pulse_stretcher against a timeline model
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int Q  = 3;
  localparam int PW = $clog2(Q + 1);

  logic          clk_in;
  logic          rst_n_in;
  logic          pulse_in;
  logic          level_out;
  logic          busy_out;
  logic [PW-1:0] pending_out;
  logic          overflow_out;

  int total;
  int bad;

  // Model: absolute cycle numbers of the current window's last high cycle and
  // last gap cycle, plus a plain integer count of queued events.
  int m_t;
  bit m_active;
  int m_hold_end;
  int m_gap_end;
  int m_pend;
  bit m_ovf;

  pulse_stretcher #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .QUEUE_DEPTH(Q),
    .CNT_W      (8)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .pulse_in    (pulse_in),
    .level_out   (level_out),
    .busy_out    (busy_out),
    .pending_out (pending_out),
    .overflow_out(overflow_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, m_t);
    end
  endtask

  task automatic model_reset();
    m_t      = 0;
    m_active = 0;
    m_pend   = 0;
    m_ovf    = 0;
  endtask

  task automatic model_step(input bit p);
    int nt;
    bit novf;
    int eff;
    nt   = m_t + 1;
    novf = 0;
    if (!m_active) begin
      if (p) begin
        m_active   = 1;
        m_hold_end = nt + H - 1;
        m_gap_end  = m_hold_end + G;
      end
    end else if (m_t == m_gap_end) begin
      eff = m_pend + int'(p);
      if (eff > 0) begin
        m_hold_end = nt + H - 1;
        m_gap_end  = m_hold_end + G;
        m_pend     = eff - 1;
      end else begin
        m_active = 0;
      end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    end else if (p && m_t <= m_hold_end) begin
      m_hold_end = nt + H - 1;
      m_gap_end  = m_hold_end + G;
`endif
    end else if (p) begin
      if (m_pend == Q) novf = 1;
      else m_pend++;
    end
    m_ovf = novf;
    m_t   = nt;
  endtask

  task automatic check_outputs();
    chk("level", level_out, (m_active && m_t <= m_hold_end) ? 1 : 0);
    chk("busy", busy_out, m_active ? 1 : 0);
    chk("pending", pending_out, m_pend);
    chk("overflow", overflow_out, m_ovf ? 1 : 0);
  endtask

  task automatic step(input bit p);
    pulse_in = p;
    model_step(p);
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic run_pat(input logic [31:0] pat, input int n,
                         output logic [31:0] lv, output logic [31:0] bv,
                         output int novf, output int nwin, output int maxp);
    lv = '0; bv = '0; novf = 0; nwin = 0; maxp = 0;
    for (int c = 0; c < n; c++) begin
      step(pat[c]);
      lv[c] = level_out;
      bv[c] = busy_out;
      if (overflow_out) novf++;
      if (level_out && (c == 0 || !lv[c-1])) nwin++;
      if (int'(pending_out) > maxp) maxp = int'(pending_out);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  logic [31:0] lv;
  logic [31:0] bv;
  int novf;
  int nwin;
  int maxp;

  initial begin
    total    = 0;
    bad      = 0;
    rst_n_in = 1'b0;
    pulse_in = 1'b0;
    model_reset();
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    chk("rst_level", level_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_pending", pending_out, 0);
    chk("rst_overflow", overflow_out, 0);
    rst_n_in = 1'b1;
    idle(3);

    // 1: single pulse
    model_reset();
    run_pat(32'h1, 8, lv, bv, novf, nwin, maxp);
    chk("t1_level", lv[7:0], 8'b0000_1111);
    chk("t1_busy", bv[7:0], 8'b0011_1111);
    chk("t1_pend", maxp, 0);
    idle(4);

    // 4: pulse exactly on last gap cycle
    run_pat(32'h41, 13, lv, bv, novf, nwin, maxp);
    chk("t4_level", lv[12:0], 13'b0_0011_1100_1111);
    chk("t4_busy", bv[12:0], 13'b0_1111_1111_1111);
    chk("t4_pend", maxp, 0);
    idle(4);

`ifndef PULSE_STRETCHER_RETRIGGER_EN
    // 2: second pulse queued during hold
    run_pat(32'h5, 13, lv, bv, novf, nwin, maxp);
    chk("t2_level", lv[12:0], 13'b0_0011_1100_1111);
    chk("t2_busy", bv[12:0], 13'b0_1111_1111_1111);
    chk("t2_pend", maxp, 1);
    idle(4);

    // 3: burst of six strobes saturates the queue
    run_pat(32'h3f, 30, lv, bv, novf, nwin, maxp);
    chk("t3_maxpend", maxp, Q);
    chk("t3_ovf", novf, 2);
    chk("t3_windows", nwin, 4);
    idle(4);

    // 5: asynchronous reset mid-hold with two queued
    run_pat(32'h7, 3, lv, bv, novf, nwin, maxp);
    chk("t5_pend_before", pending_out, 2);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("t5_rst_level", level_out, 0);
    chk("t5_rst_busy", busy_out, 0);
    chk("t5_rst_pending", pending_out, 0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    run_pat(32'h1, 12, lv, bv, novf, nwin, maxp);
    chk("t5_level", lv[11:0], 12'b0000_0000_1111);
    chk("t5_windows", nwin, 1);
    idle(4);
`else
    // 6: retrigger extends the window
    run_pat(32'h9, 10, lv, bv, novf, nwin, maxp);
    chk("t6_level", lv[9:0], 10'b00_0111_1111);
    chk("t6_pend", maxp, 0);
    chk("t6_ovf", novf, 0);
    idle(4);
`endif

    // Random phases with differing strobe density.
    for (int ph = 0; ph < 6; ph++) begin
      int den;
      den = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 8 : 25);
      for (int i = 0; i < 400; i++) step(($urandom % den) == 0);
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
